// File: rtl/shift_unit_pkg.sv
// Shared opcodes, FSM encoding and opcode legality for the multi-cycle shifter.
// SHIFT_UNIT_ROTATE_EN enables the ROR/ROL opcodes; without it they pass the operand through.
package shift_unit_pkg;

  localparam logic [2:0] OP_SRL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [2:0] fun);
`ifdef SHIFT_UNIT_ROTATE_EN
    return (fun <= OP_ROL);
`else
    return (fun <= OP_SRA);
`endif
  endfunction

endpackage

// File: rtl/shift_unit_seq_step.sv
// Combinational single-step shifter: moves data by amt (<= STEP) positions.
// Rotate modes exist only when SHIFT_UNIT_ROTATE_EN is defined.
module shift_step
  import shift_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 4,
  parameter int AW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    amt,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  // Unrolled one bit per stage so the carry naturally ends up as the last bit out.
  always_comb begin
    result = data;
    carry  = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(amt)) begin
        case (op)
          OP_SRL: begin
            carry  = result[0];
            result = {1'b0, result[WIDTH-1:1]};
          end
          OP_SLL: begin
            carry  = result[WIDTH-1];
            result = {result[WIDTH-2:0], 1'b0};
          end
          OP_SRA: begin
            carry  = result[0];
            result = {result[WIDTH-1], result[WIDTH-1:1]};
          end
`ifdef SHIFT_UNIT_ROTATE_EN
          OP_ROR: begin
            carry  = result[0];
            result = {result[0], result[WIDTH-1:1]};
          end
          OP_ROL: begin
            carry  = result[WIDTH-1];
            result = {result[WIDTH-2:0], result[WIDTH-1]};
          end
`endif
          default: begin
            carry  = carry;
            result = result;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shift/rotate unit with start/busy/done handshake, up to STEP bits per cycle.
// Rotate opcodes are built only with SHIFT_UNIT_ROTATE_EN defined.
//
// state    | meaning
// ST_IDLE  | waiting for Shift_Enable, result held
// ST_SHIFT | applying min(STEP, remaining) positions per cycle
// ST_DONE  | one-cycle done pulse, result valid
module shift_unit_seq
  import shift_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [WIDTH-1:0]         A,
  input  logic [WIDTH-1:0]         B,
  input  logic                     SRC_SEL,
  input  logic [2:0]               ALU_FUN,
  input  logic [$clog2(WIDTH)-1:0] SHAMT,
  input  logic                     Shift_Enable,
  output logic [WIDTH-1:0]         Shift_OUT,
  output logic                     Shift_Flag,
  output logic                     Shift_Busy,
  output logic                     Shift_Carry
);

  localparam int SW = $clog2(WIDTH);
  localparam int AW = $clog2(STEP + 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] work;
  logic [2:0]       op;
  logic [SW-1:0]    rem;
  logic [SW-1:0]    k_rem;
  logic [AW-1:0]    step_amt;
  logic [WIDTH-1:0] step_out;
  logic             step_carry;
  logic             carry_q, flag_q, busy_q;

  shift_step #(.WIDTH(WIDTH), .STEP(STEP), .AW(AW)) u_step (
    .data   (work),
    .op     (op),
    .amt    (step_amt),
    .result (step_out),
    .carry  (step_carry)
  );

  // remaining < WIDTH, so k_rem only takes the STEP value when STEP itself fits
  always_comb begin
    k_rem = rem;
    if (int'(rem) > STEP) k_rem = SW'(STEP);
    step_amt = AW'(k_rem);
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (Shift_Enable)
          state_next = (SHAMT != '0 && op_legal(ALU_FUN)) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        if (rem == k_rem) state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= ST_IDLE;
      work    <= '0;
      op      <= OP_SRL;
      rem     <= '0;
      carry_q <= 1'b0;
      flag_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state  <= state_next;
      flag_q <= (state_next == ST_DONE);
      busy_q <= (state_next != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (Shift_Enable) begin
            work    <= SRC_SEL ? B : A;
            op      <= ALU_FUN;
            rem     <= SHAMT;
            carry_q <= 1'b0;
          end
        end
        ST_SHIFT: begin
          work    <= step_out;
          carry_q <= step_carry;
          rem     <= rem - k_rem;
        end
        default: ;
      endcase
    end
  end

  assign Shift_OUT   = work;
  assign Shift_Flag  = flag_q;
  assign Shift_Busy  = busy_q;
  assign Shift_Carry = carry_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed self-checking bench for shift_unit_seq (WIDTH=16, STEP=4).
// Expected rotate results follow SHIFT_UNIT_ROTATE_EN.
module tb_shift_unit_seq;
  import shift_unit_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic        SRC_SEL = 1'b0;
  logic [2:0]  ALU_FUN = '0;
  logic [3:0]  SHAMT = '0;
  logic        Shift_Enable = 1'b0;
  logic [15:0] Shift_OUT;
  logic        Shift_Flag, Shift_Busy, Shift_Carry;

  int total = 0;
  int bad   = 0;

  shift_unit_seq #(.WIDTH(16), .STEP(4)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .A            (A),
    .B            (B),
    .SRC_SEL      (SRC_SEL),
    .ALU_FUN      (ALU_FUN),
    .SHAMT        (SHAMT),
    .Shift_Enable (Shift_Enable),
    .Shift_OUT    (Shift_OUT),
    .Shift_Flag   (Shift_Flag),
    .Shift_Busy   (Shift_Busy),
    .Shift_Carry  (Shift_Carry)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

`ifdef SHIFT_UNIT_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  // Start an op at edge E, then sample #1 after each edge until Busy drops.
  // restart: hold Shift_Enable high (with a different A) while the op is in flight.
  task automatic run_op(input string tag, input logic src, input logic [2:0] fun,
                        input logic [15:0] a, input logic [15:0] b, input logic [3:0] sh,
                        input logic [15:0] exp_out, input logic exp_c, input int exp_n,
                        input bit restart);
    int flag_at = -1, flags = 0, busy_cnt = 0;
    logic [15:0] out_at_flag = '0;
    logic        c_at_flag = 1'b0;
    @(negedge CLK);
    A = a; B = b; SRC_SEL = src; ALU_FUN = fun; SHAMT = sh; Shift_Enable = 1'b1;
    @(posedge CLK); #1;
    Shift_Enable = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!Shift_Busy) break;
      busy_cnt++;
      if (Shift_Flag) begin
        flags++;
        if (flag_at < 0) begin
          flag_at = c; out_at_flag = Shift_OUT; c_at_flag = Shift_Carry;
        end
        Shift_Enable = 1'b0;
      end else if (restart) begin
        A = 16'hFFFF; B = 16'hFFFF; ALU_FUN = OP_SLL; Shift_Enable = 1'b1;
      end
      @(posedge CLK); #1;
    end
    Shift_Enable = 1'b0;
    chk({tag, "_flag_cycle"}, flag_at, exp_n);
    chk({tag, "_flag_pulses"}, flags, 1);
    chk({tag, "_busy_cycles"}, busy_cnt, exp_n + 1);
    chk({tag, "_out"}, out_at_flag, exp_out);
    chk({tag, "_carry"}, c_at_flag, exp_c);
    @(posedge CLK); #1;
    chk({tag, "_hold"}, {Shift_OUT, Shift_Carry, Shift_Busy}, {exp_out, exp_c, 1'b0});
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_outputs", {Shift_OUT, Shift_Flag, Shift_Busy, Shift_Carry}, '0);
    @(negedge CLK); RST = 1'b1;

    run_op("srl1",    1'b0, OP_SRL, 16'h8001, 16'h0, 4'd1,  16'h4000, 1'b1, 1, 1'b0);
    run_op("sra15",   1'b0, OP_SRA, 16'h8000, 16'h0, 4'd15, 16'hFFFF, 1'b0, 4, 1'b0);
    run_op("sra_pos", 1'b0, OP_SRA, 16'h7000, 16'h0, 4'd4,  16'h0700, 1'b0, 1, 1'b0);
    run_op("sll9",    1'b0, OP_SLL, 16'h00FF, 16'h0, 4'd9,  16'hFE00, 1'b1, 3, 1'b0);
    run_op("rol4",    1'b1, OP_ROL, 16'h0000, 16'h1234, 4'd4,
           ROT ? 16'h2341 : 16'h1234, ROT, ROT ? 1 : 0, 1'b0);
    run_op("ror3",    1'b1, OP_ROR, 16'h0000, 16'h1234, 4'd3,
           ROT ? 16'h8246 : 16'h1234, ROT, ROT ? 1 : 0, 1'b0);
    run_op("shamt0",  1'b0, OP_SRL, 16'hABCD, 16'h0, 4'd0,  16'hABCD, 1'b0, 0, 1'b0);
    run_op("illegal", 1'b0, 3'b111, 16'hABCD, 16'h0, 4'd5,  16'hABCD, 1'b0, 0, 1'b0);
    run_op("restart", 1'b0, OP_SLL, 16'h00FF, 16'h0, 4'd9,  16'hFE00, 1'b1, 3, 1'b1);

    // reset in the middle of a long SRA
    @(negedge CLK);
    A = 16'h8000; SRC_SEL = 1'b0; ALU_FUN = OP_SRA; SHAMT = 4'd15; Shift_Enable = 1'b1;
    @(posedge CLK); #1;
    Shift_Enable = 1'b0;
    @(posedge CLK); #1;
    chk("mid_busy", Shift_Busy, 1'b1);
    RST = 1'b0;
    #1;
    chk("mid_reset_outputs", {Shift_OUT, Shift_Flag, Shift_Busy, Shift_Carry}, '0);
    @(negedge CLK); RST = 1'b1;
    run_op("post_reset", 1'b0, OP_SRL, 16'h0010, 16'h0, 4'd4, 16'h0001, 1'b0, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_unit_seq.md
# shift_unit_seq

Parametrised multi-cycle shift/rotate unit for the ALU datapath. It is the successor to the fixed 1-bit shifter. It shifts a selected operand by a run-time amount of 0..WIDTH-1 and supports logical, arithmetic and (optionally) rotate modes. Each cycle moves up to STEP bit positions, so a wide shift costs several cycles. A start/busy/done handshake connects it to the ALU controller.

## Interface
- WIDTH, 16, operand and result width (≥2)
- STEP, 4, maximum bit positions shifted per cycle (1..WIDTH)
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous reset, active-low
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- SRC_SEL  in  1  0 = shift A, 1 = shift B
- ALU_FUN  in  3  operation: 000 SRL, 001 SLL, 010 SRA, 011 ROR, 100 ROL, 101–111 illegal
- SHAMT  in  $clog2(WIDTH)  shift amount
- Shift_Enable  in  1  start request, sampled only in IDLE
- Shift_OUT  out  WIDTH  result, registered
- Shift_Flag  out  1  done, one-cycle pulse
- Shift_Busy  out  1  high whenever FSM ≠ IDLE
- Shift_Carry  out  1  last bit shifted/rotated out

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset → IDLE; all outputs 0.
- IDLE & Shift_Enable=1 at edge E:
  - Latch the operand (per SRC_SEL), opcode and SHAMT. Clear the carry.
  - Go to SHIFT if SHAMT>0, else DONE.
- SHIFT: each edge applies k = min(STEP, remaining) positions and decrements remaining by k. Go to DONE when remaining reaches 0.
- N = ceil(SHAMT/STEP) shift cycles.
- DONE: Shift_Flag=1 for exactly one cycle, then IDLE.
- Shift_OUT tracks the working register. It is valid while Shift_Flag=1 and holds until the next accepted start.
- Modes:
  - SRL and SLL fill with 0.
  - SRA fills with the original MSB.
  - ROR and ROL wrap.
- Shift_Carry:
  - SRL/SRA/ROR: the last bit to leave the LSB.
  - SLL/ROL: the last bit to leave the MSB.
  - 0 when SHAMT=0.
- Illegal opcode: treated as SHAMT=0, so Shift_OUT = operand, carry 0, Shift_Flag still pulses.
- Shift_Enable in SHIFT or DONE is ignored, with no queuing. Operand and opcode changes during SHIFT have no effect.
- Reset asserted mid-operation: the in-flight op is discarded immediately and outputs are 0. The first start after release is handled normally.

## Timing
- Start sampled at edge E.
- Shift_Flag is high during the cycle after edge E+N. For N=0 this is the cycle right after E.
- Earliest next accepted start is at edge E+N+2. Throughput is one op per N+2 cycles.
- Shift_Busy rises after E and falls after edge E+N+1.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- SHIFT_UNIT_ROTATE_EN defined: ROR/ROL are implemented as above.
- Not defined: opcodes 011 and 100 are illegal, following the illegal-opcode rule (passthrough, carry 0, flag pulse), and the rotate logic is removed.

## Structure
- Package shift_unit_pkg holds:
  - opcode localparams (OP_SRL, OP_SLL, OP_SRA, OP_ROR, OP_ROL);
  - FSM state encoding (ST_IDLE, ST_SHIFT, ST_DONE).
- Sub-module shift_step: combinational single-step shifter. Inputs are operand, opcode and amount k ≤ STEP; outputs are the shifted value and carry-out. The top instantiates it once.

## Test plan
WIDTH=16, STEP=4, macro defined unless noted.
- SRL, A=0x8001, SHAMT=1 → Shift_OUT=0x4000, carry 1, flag in the cycle after E+1.
- SRA, A=0x8000, SHAMT=15 → 0xFFFF, carry 0, N=4, Busy high for 5 cycles.
- SLL, A=0x00FF, SHAMT=9 → steps 4,4,1 giving 0xFE00, carry 1.
- ROL, SRC_SEL=1, B=0x1234, SHAMT=4 → 0x2341, carry 1. With the macro undefined → 0x1234, carry 0, flag still pulses.
- SHAMT=0 and illegal opcode 111, A=0xABCD → 0xABCD, carry 0, flag in the cycle right after E.
- Start re-asserted during SHIFT is ignored and the result is unchanged. Reset mid-SHIFT clears all outputs to 0 and returns to IDLE; a following SRL 0x0010 by 4 → 0x0001.
